// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD angle display.
package lcd_pkg;

  // Frame-level sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StAddr,
    StChar,
    StDone
  } lcd_state_t;

  // Sub-phases of a single bus write
  typedef enum logic [1:0] {
    PhSetup,
    PhPulse,
    PhHold
  } lcd_phase_t;

  // Angle converter states
  typedef enum logic [1:0] {
    CvIdle,
    CvReduce,
    CvDabble
  } conv_state_t;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] ASCII_ZERO        = 8'h30;
  localparam logic [7:0] LCD_DEG_CHAR      = 8'hDF;

  // Whole degrees 0..359 fit in 9 bits
  localparam int unsigned DEG_BIN_W = 9;

endpackage

// File: rtl/angle_to_bcd.sv
// Raw encoder angle -> rounded whole degrees -> zero-padded BCD digits.
// Sequence: modulo reduction by repeated subtraction, one-cycle scale/round/wrap,
// then one double-dabble shift per cycle. conv_done pulses once; bcd holds until next start.
module angle_to_bcd
  import lcd_pkg::*;
#(
  parameter int unsigned ANGLE_W        = 12,
  parameter int unsigned COUNTS_PER_REV = 1006,
  parameter int unsigned DIGITS         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ANGLE_W-1:0]    angle,
  output logic                  conv_done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned PW   = DEG_BIN_W + ANGLE_W;
  localparam int unsigned BcdW = 4 * DIGITS;

  localparam logic [ANGLE_W:0] Counts  = (ANGLE_W + 1)'(COUNTS_PER_REV);
  localparam logic [PW-1:0]    CountsP = PW'(COUNTS_PER_REV);
  localparam logic [PW-1:0]    Deg360  = PW'(360);

  conv_state_t             state_q, state_d;
  logic [ANGLE_W-1:0]      a_q, a_d;
  logic [DEG_BIN_W-1:0]    bin_q, bin_d;
  logic [BcdW-1:0]         bcd_q, bcd_d, bcd_adj;
  logic [3:0]              shift_q, shift_d;
  logic                    done_q, done_d;
  logic [PW-1:0]           prod, quo, rem, q_round;
  logic [DEG_BIN_W-1:0]    deg;

  // Scale reduced count to degrees, round half-up, fold 360 back to 0
  always_comb begin
    prod    = PW'(a_q) * Deg360;
    quo     = prod / CountsP;
    rem     = prod - quo * CountsP;
    q_round = ({rem, 1'b0} >= {1'b0, CountsP}) ? quo + PW'(1) : quo;
    deg     = (q_round == Deg360) ? '0 : DEG_BIN_W'(q_round);
  end

  // Converter next-state: reduce, scale, then shift-and-add-3
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      CvIdle: begin
        if (start) begin
          a_d     = angle;
          state_d = CvReduce;
        end
      end
      CvReduce: begin
        if ({1'b0, a_q} >= Counts) begin
          a_d = ANGLE_W'({1'b0, a_q} - Counts);
        end else begin
          bin_d   = deg;
          bcd_d   = '0;
          shift_d = '0;
          state_d = CvDabble;
        end
      end
      CvDabble: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        shift_d        = shift_q + 4'd1;
        if (shift_q == 4'(DEG_BIN_W - 1)) begin
          state_d = CvIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = CvIdle;
    endcase
  end

  // Converter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CvIdle;
      a_q     <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign conv_done = done_q;
  assign bcd       = bcd_q;

endmodule

// File: rtl/lcd_angle_display.sv
// HD44780-style writer: periodically (or on request) converts the encoder angle and
// writes set-DDRAM-address followed by the degree digits, MSD first.
// Optional macro DEG_SYMBOL_EN appends a degree-sign character after the digits.
module lcd_angle_display
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned REFRESH_HZ     = 30,
  parameter int unsigned ANGLE_W        = 12,
  parameter int unsigned COUNTS_PER_REV = 1006,
  parameter int unsigned DIGITS         = 3,
  parameter logic [6:0]  DDRAM_ADDR     = 7'h00,
  parameter int unsigned E_PULSE_CYC    = 1000,
  parameter int unsigned GAP_CYC        = 1000,
  parameter int unsigned CMD_WAIT_CYC   = 2500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               force_refresh,
  output logic [7:0]         data,
  output logic               rs,
  output logic               rw,
  output logic               e,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned RefreshMax = CLK_HZ / REFRESH_HZ - 1;
  localparam int unsigned RefW       = (RefreshMax > 0) ? $clog2(RefreshMax + 1) : 1;
`ifdef DEG_SYMBOL_EN
  localparam int unsigned NumChars   = DIGITS + 1;
`else
  localparam int unsigned NumChars   = DIGITS;
`endif
  // Command write holds longer: gap plus the controller's address-set settle time
  localparam int unsigned AddrHold   = GAP_CYC + CMD_WAIT_CYC;
  localparam int unsigned CntMax     = (E_PULSE_CYC > AddrHold) ? E_PULSE_CYC : AddrHold;
  localparam int unsigned CntW       = $clog2(CntMax + 1);
  localparam int unsigned IdxW       = $clog2(NumChars + 1);

  lcd_state_t          state_q, state_d;
  lcd_phase_t          phase_q, phase_d;
  logic [CntW-1:0]     cnt_q, cnt_d, hold_last;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [7:0]          data_q, data_d;
  logic                rs_q, rs_d, e_q, e_d;
  logic                busy_q, frame_done_q;
  logic [ANGLE_W-1:0]  angle_q, angle_d;
  logic                conv_start_q, conv_start_d;
  logic [RefW-1:0]     ref_q;
  logic                tick, req, write_end, conv_done;
  logic [4*DIGITS-1:0] bcd;

  // Character byte for position idx: digits MSD first, then optional degree sign
  function automatic logic [7:0] char_at(input logic [IdxW-1:0] idx,
                                         input logic [4*DIGITS-1:0] b);
    logic [3:0] dig;
    dig = '0;
`ifdef DEG_SYMBOL_EN
    if (idx == IdxW'(DIGITS)) return LCD_DEG_CHAR;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IdxW'(DIGITS - 1 - i)) dig = b[4*i +: 4];
    end
    return ASCII_ZERO + {4'h0, dig};
  endfunction

  assign tick = (ref_q == RefW'(RefreshMax));
  assign req  = tick | force_refresh;

  // Free-running refresh timer; tick on wrap
  always_ff @(posedge clk) begin
    if (reset || tick) ref_q <= '0;
    else               ref_q <= ref_q + RefW'(1);
  end

  angle_to_bcd #(
    .ANGLE_W        (ANGLE_W),
    .COUNTS_PER_REV (COUNTS_PER_REV),
    .DIGITS         (DIGITS)
  ) u_conv (
    .clk       (clk),
    .reset     (reset),
    .start     (conv_start_q),
    .angle     (angle_q),
    .conv_done (conv_done),
    .bcd       (bcd)
  );

  // Frame FSM and write sub-phase sequencer; data/rs only change on entering SETUP
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    data_d       = data_q;
    rs_d         = rs_q;
    e_d          = e_q;
    angle_d      = angle_q;
    conv_start_d = 1'b0;
    write_end    = 1'b0;
    hold_last    = (state_q == StAddr) ? CntW'(AddrHold - 1) : CntW'(GAP_CYC - 1);

    if (state_q inside {StAddr, StChar}) begin
      unique case (phase_q)
        PhSetup: begin
          phase_d = PhPulse;
          e_d     = 1'b1;
          cnt_d   = '0;
        end
        PhPulse: begin
          if (cnt_q == CntW'(E_PULSE_CYC - 1)) begin
            phase_d = PhHold;
            e_d     = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        PhHold: begin
          if (cnt_q == hold_last) write_end = 1'b1;
          else                    cnt_d     = cnt_q + CntW'(1);
        end
        default: phase_d = PhSetup;
      endcase
    end

    // Requests during a frame collapse into one deferred frame
    if (req && state_q != StIdle) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d      = StConv;
          angle_d      = angle;
          conv_start_d = 1'b1;
        end
      end
      StConv: begin
        if (conv_done) begin
          state_d = StAddr;
          phase_d = PhSetup;
          cnt_d   = '0;
          data_d  = LCD_CMD_SET_DDRAM | {1'b0, DDRAM_ADDR};
          rs_d    = 1'b0;
        end
      end
      StAddr: begin
        if (write_end) begin
          state_d = StChar;
          idx_d   = '0;
          phase_d = PhSetup;
          cnt_d   = '0;
          data_d  = char_at(IdxW'(0), bcd);
          rs_d    = 1'b1;
        end
      end
      StChar: begin
        if (write_end) begin
          if (idx_q == IdxW'(NumChars - 1)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            phase_d = PhSetup;
            cnt_d   = '0;
            data_d  = char_at(idx_q + IdxW'(1), bcd);
          end
        end
      end
      StDone: begin
        if (pending_q || req) begin
          state_d      = StConv;
          pending_d    = 1'b0;
          angle_d      = angle;
          conv_start_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame state and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= PhSetup;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      angle_q      <= '0;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      e_q          <= e_d;
      busy_q       <= (state_d != StIdle);
      frame_done_q <= (state_d == StDone);
      angle_q      <= angle_d;
      conv_start_q <= conv_start_d;
    end
  end

  assign data       = data_q;
  assign rs         = rs_q;
  assign rw         = 1'b0;
  assign e          = e_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
